spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
- Two-requester arbiter sharing the single byte-wide SPI SRAM memory port (mem_* bus) between the CPU cache (port 0) and a secondary master such as a DMA/loader engine (port 1).
- Sits between the requesters and spi_sram_master, and is transparent to both sides.
- Port 0 has priority. A starvation counter guarantees port 1 progress.
- A grant is held for a whole transaction, including multi-byte bursts.

Parameters:
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 is pending before port 1 is forced to win. 0 = strict port-0 priority. Range 0..15.
- AW, 24: memory address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- p0_addr / p1_addr  in  AW  byte address
- p0_en / p1_en  in  1  request. Held high with attributes stable until the transaction completes.
- p0_wr / p1_wr  in  1  1 = write, 0 = read
- p0_rburst / p1_rburst  in  1  continue read burst past the current byte
- p0_wburst / p1_wburst  in  1  continue write burst past the current byte
- p0_wdata / p1_wdata  in  8  write byte
- p0_rdy / p1_rdy  out  1  byte-complete strobe, gated to the granted port
- p0_rdata / p1_rdata  out  8  read byte (mem_rdata broadcast)
- p0_rdata0 / p1_rdata0  out  8  early read byte (mem_rdata0 broadcast)
- p0_rdata_load / p1_rdata_load  out  1  early-data load strobe, gated to the granted port
- gnt  out  2  one-hot current grant. 00 = idle.
- mem_addr  out  AW  to SPI master
- mem_en, mem_wr, mem_rburst, mem_wburst  out  1  to SPI master
- mem_wdata  out  8  to SPI master
- mem_rdy  in  1  from SPI master
- mem_rdata, mem_rdata0  in  8  from SPI master
- mem_rdata_load  in  1  from SPI master

Behaviour:

Handshake:
- A transaction is one or more bytes.
- mem_rdy pulses for one cycle per byte completed. Read data is valid on mem_rdata in that cycle.
- If the granted port's rburst or wburst (as selected by wr) is high in a mem_rdy cycle, the transaction continues.
- If it is low in a mem_rdy cycle, that byte completes the transaction.

FSM states: IDLE, GNT0, GNT1.
- IDLE: gnt=00 and mem_en=0. All other mem_* outputs are driven from port 0 (don't-care).
  - Arbitration is evaluated on registered state at the clock edge. The winner is entered next cycle.
  - p1_en && (!p0_en || starve_cnt>=STARVE_LIMIT, with STARVE_LIMIT!=0) → GNT1.
  - else p0_en → GNT0.
  - else stay in IDLE.
- GNT0 / GNT1: all mem_* outputs are combinationally muxed from the granted port.
  - mem_rdy → granted p*_rdy; mem_rdata_load → granted p*_rdata_load. The non-granted strobes are held 0.
  - Exit to IDLE on the cycle after mem_rdy with the selected burst bit low.
- Latency:
  - p*_en rising in IDLE at cycle N → mem_en high at N+1.
  - After completion there is at least one IDLE cycle (mem_en low), so the SPI master sees a cs_n boundary.
  - Back-to-back transactions from one port therefore have a 2-cycle turnaround: completion rdy, then IDLE, then the next grant.
- Starvation counter starve_cnt (4 bits, saturating at 15):
  - Increments on each IDLE→GNT0 transition while p1_en=1.
  - Clears on IDLE→GNT1 and whenever p1_en=0 in IDLE.
- Granted port dropping p*_en before its completing rdy is a protocol violation. The arbiter keeps the grant and waits for completion; the bench flags it as an assertion.
- Simultaneous events:
  - Completion rdy and a new request from the other port in the same cycle: the new request is arbitrated in the following IDLE cycle.
  - Both ports requesting in IDLE with starve_cnt below the limit: port 0 wins.
- Reset:
  - Values: state=IDLE, gnt=00, mem_en=0, p*_rdy=0, p*_rdata_load=0, starve_cnt=0.
  - Reset mid-transaction drops mem_en in the next cycle. The SPI master is reset from the same rst, so no partial burst resumes.
- p*_rdata and p*_rdata0 are unconditional broadcasts of mem_rdata and mem_rdata0 and carry no reset requirement.

Test Plan:
- Single read, port 0: p0_en=1, addr=0x001234, wr=0, bursts=0. Required: mem_en at +1 cycle, mem_addr=0x001234, gnt=01. Slave rdy with rdata=0xA5 → p0_rdy=1, p0_rdata=0xA5, p1_rdy=0. IDLE next cycle.
- Burst write, port 1: p1_wburst=1 for 3 bytes, then 0 on the 4th rdy. Required: gnt=10 held through 4 rdys, mem_wburst tracks p1. Release after the 4th rdy; p0_rdy stays 0 throughout.
- Contention, STARVE_LIMIT=2: both ports request continuously with single-byte transactions. Required grant order 0,0,1,0,0,1. Each grant is separated by exactly one IDLE cycle with mem_en=0.
- STARVE_LIMIT=0, both ports requesting continuously: port 1 is never granted.
- Early data: mem_rdata_load pulses during a GNT1 read. Required: p1_rdata_load=1, p0_rdata_load=0, p1_rdata0 equals mem_rdata0.
- Reset mid-burst: assert rst during the 2nd byte of a port-0 burst. Required next cycle: mem_en=0, gnt=00, starve_cnt=0. After rst is released, a pending p1_en is granted first if p0_en=0.

Source files
------------

// File: rtl/spi_mem_arbiter.sv
// Two-port arbiter sharing one byte-wide SPI SRAM port between the CPU cache (port 0)
// and a secondary master (port 1); port 0 has priority, bounded by a starvation counter.
module spi_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 24
) (
  input  logic          clk,
  input  logic          rst,

  input  logic [AW-1:0] p0_addr,
  input  logic          p0_en,
  input  logic          p0_wr,
  input  logic          p0_rburst,
  input  logic          p0_wburst,
  input  logic [7:0]    p0_wdata,
  output logic          p0_rdy,
  output logic [7:0]    p0_rdata,
  output logic [7:0]    p0_rdata0,
  output logic          p0_rdata_load,

  input  logic [AW-1:0] p1_addr,
  input  logic          p1_en,
  input  logic          p1_wr,
  input  logic          p1_rburst,
  input  logic          p1_wburst,
  input  logic [7:0]    p1_wdata,
  output logic          p1_rdy,
  output logic [7:0]    p1_rdata,
  output logic [7:0]    p1_rdata0,
  output logic          p1_rdata_load,

  output logic [1:0]    gnt,

  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_wr,
  output logic          mem_rburst,
  output logic          mem_wburst,
  output logic [7:0]    mem_wdata,
  input  logic          mem_rdy,
  input  logic [7:0]    mem_rdata,
  input  logic [7:0]    mem_rdata0,
  input  logic          mem_rdata_load
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_GNT0 = 2'b01;
  localparam logic [1:0] ST_GNT1 = 2'b10;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       p0_last, p1_last, p1_starved, sel1;

  always_comb begin
    p0_last    = !(p0_wr ? p0_wburst : p0_rburst);
    p1_last    = !(p1_wr ? p1_wburst : p1_rburst);
    p1_starved = (LIMIT != 4'd0) && (starve_cnt_q >= LIMIT);
  end

  // Arbitrate only from IDLE; a grant is held until the byte that ends the burst.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (p1_en && (!p0_en || p1_starved)) begin
          state_d      = ST_GNT1;
          starve_cnt_d = 4'd0;
        end else if (p0_en) begin
          state_d = ST_GNT0;
          if (!p1_en) begin
            starve_cnt_d = 4'd0;
          end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
          end
        end else begin
          starve_cnt_d = 4'd0;
        end
      end
      ST_GNT0: begin
        if (mem_rdy && p0_last) state_d = ST_IDLE;
      end
      ST_GNT1: begin
        if (mem_rdy && p1_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Port 0 drives the memory bus while idle; mem_en alone marks it as meaningful.
  always_comb begin
    sel1       = (state_q == ST_GNT1);
    gnt        = state_q;
    mem_en     = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    mem_addr   = sel1 ? p1_addr   : p0_addr;
    mem_wr     = sel1 ? p1_wr     : p0_wr;
    mem_rburst = sel1 ? p1_rburst : p0_rburst;
    mem_wburst = sel1 ? p1_wburst : p0_wburst;
    mem_wdata  = sel1 ? p1_wdata  : p0_wdata;

    p0_rdy        = mem_rdy && (state_q == ST_GNT0);
    p1_rdy        = mem_rdy && sel1;
    p0_rdata_load = mem_rdata_load && (state_q == ST_GNT0);
    p1_rdata_load = mem_rdata_load && sel1;

    p0_rdata  = mem_rdata;
    p1_rdata  = mem_rdata;
    p0_rdata0 = mem_rdata0;
    p1_rdata0 = mem_rdata0;
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: two instances (starvation limit 2 and strict priority) share
// stimulus and are compared every cycle against a transaction-level arbitration model.
module tb_spi_mem_arbiter;

  localparam int LIM_A = 2;
  localparam int LIM_B = 0;

  logic        clk, rst;
  logic [23:0] p0_addr, p1_addr;
  logic        p0_en, p1_en, p0_wr, p1_wr;
  logic        p0_rburst, p1_rburst, p0_wburst, p1_wburst;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        mem_rdy, mem_rdata_load;
  logic [7:0]  mem_rdata, mem_rdata0;

  logic        a_p0_rdy, a_p1_rdy, a_p0_load, a_p1_load;
  logic [7:0]  a_p0_rdata, a_p1_rdata, a_p0_rdata0, a_p1_rdata0;
  logic [1:0]  a_gnt;
  logic [23:0] a_mem_addr;
  logic        a_mem_en, a_mem_wr, a_mem_rburst, a_mem_wburst;
  logic [7:0]  a_mem_wdata;

  logic        b_p0_rdy, b_p1_rdy, b_p0_load, b_p1_load;
  logic [7:0]  b_p0_rdata, b_p1_rdata, b_p0_rdata0, b_p1_rdata0;
  logic [1:0]  b_gnt;
  logic [23:0] b_mem_addr;
  logic        b_mem_en, b_mem_wr, b_mem_rburst, b_mem_wburst;
  logic [7:0]  b_mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns the memory (-1 = nobody) and how often port 1 was passed over.
  int m_owner [2] = '{-1, -1};
  int m_passed[2] = '{0, 0};
  bit byte_done[2] = '{0, 0};

  bit          pend [2];
  int          left [2];
  bit          rwr  [2];
  bit          rother[2];
  logic [23:0] raddr[2];
  logic [7:0]  rwdat[2];

  logic [1:0] exp_order_a [12] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2,
                                   2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2};

  spi_mem_arbiter #(.STARVE_LIMIT(LIM_A), .AW(24)) dut_a (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_en(p0_en), .p0_wr(p0_wr), .p0_rburst(p0_rburst),
    .p0_wburst(p0_wburst), .p0_wdata(p0_wdata), .p0_rdy(a_p0_rdy), .p0_rdata(a_p0_rdata),
    .p0_rdata0(a_p0_rdata0), .p0_rdata_load(a_p0_load),
    .p1_addr(p1_addr), .p1_en(p1_en), .p1_wr(p1_wr), .p1_rburst(p1_rburst),
    .p1_wburst(p1_wburst), .p1_wdata(p1_wdata), .p1_rdy(a_p1_rdy), .p1_rdata(a_p1_rdata),
    .p1_rdata0(a_p1_rdata0), .p1_rdata_load(a_p1_load),
    .gnt(a_gnt), .mem_addr(a_mem_addr), .mem_en(a_mem_en), .mem_wr(a_mem_wr),
    .mem_rburst(a_mem_rburst), .mem_wburst(a_mem_wburst), .mem_wdata(a_mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
    .mem_rdata_load(mem_rdata_load)
  );

  spi_mem_arbiter #(.STARVE_LIMIT(LIM_B), .AW(24)) dut_b (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_en(p0_en), .p0_wr(p0_wr), .p0_rburst(p0_rburst),
    .p0_wburst(p0_wburst), .p0_wdata(p0_wdata), .p0_rdy(b_p0_rdy), .p0_rdata(b_p0_rdata),
    .p0_rdata0(b_p0_rdata0), .p0_rdata_load(b_p0_load),
    .p1_addr(p1_addr), .p1_en(p1_en), .p1_wr(p1_wr), .p1_rburst(p1_rburst),
    .p1_wburst(p1_wburst), .p1_wdata(p1_wdata), .p1_rdy(b_p1_rdy), .p1_rdata(b_p1_rdata),
    .p1_rdata0(b_p1_rdata0), .p1_rdata_load(b_p1_load),
    .gnt(b_gnt), .mem_addr(b_mem_addr), .mem_en(b_mem_en), .mem_wr(b_mem_wr),
    .mem_rburst(b_mem_rburst), .mem_wburst(b_mem_wburst), .mem_wdata(b_mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .mem_rdata0(mem_rdata0),
    .mem_rdata_load(mem_rdata_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lim_of(int k);
    return (k == 0) ? LIM_A : LIM_B;
  endfunction

  function automatic bit wants_more(int p);
    if (p == 1) return p1_wr ? p1_wburst : p1_rburst;
    return p0_wr ? p0_wburst : p0_rburst;
  endfunction

  // Reference arbitration, advanced once per clock from the inputs of the ending cycle.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) byte_done[p] = !rst && mem_rdy && (m_owner[0] == p);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k]  = -1;
        m_passed[k] = 0;
      end else if (m_owner[k] >= 0) begin
        if (mem_rdy && !wants_more(m_owner[k])) m_owner[k] = -1;
      end else if (p1_en && (!p0_en || (lim_of(k) > 0 && m_passed[k] >= lim_of(k)))) begin
        m_owner[k]  = 1;
        m_passed[k] = 0;
      end else if (p0_en) begin
        m_owner[k]  = 0;
        m_passed[k] = p1_en ? m_passed[k] + 1 : 0;
      end else begin
        m_passed[k] = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compareOne(input string n, input int k, input logic [1:0] g, input logic en,
                            input logic [23:0] addr, input logic [10:0] ctl,
                            input logic [3:0] stb, input logic [31:0] bc);
    int o;
    logic [1:0] eg;
    o  = m_owner[k];
    eg = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
    checkOutput({n, ".gnt"}, 32'(g), 32'(eg));
    checkOutput({n, ".mem_en"}, 32'(en), 32'(o >= 0));
    checkOutput({n, ".strobes"}, 32'(stb),
                32'({mem_rdy && o == 0, mem_rdy && o == 1,
                     mem_rdata_load && o == 0, mem_rdata_load && o == 1}));
    checkOutput({n, ".bcast"}, bc, {mem_rdata, mem_rdata, mem_rdata0, mem_rdata0});
    if (o >= 0) begin
      checkOutput({n, ".mem_addr"}, 32'(addr), 32'((o == 1) ? p1_addr : p0_addr));
      checkOutput({n, ".mem_ctl"}, 32'(ctl),
                  32'((o == 1) ? {p1_wr, p1_rburst, p1_wburst, p1_wdata}
                               : {p0_wr, p0_rburst, p0_wburst, p0_wdata}));
    end
  endtask

  task automatic compareAll();
    if (!rst && a_gnt == 2'b01) assert (p0_en) else $error("[TB] port 0 dropped en while granted");
    if (!rst && a_gnt == 2'b10) assert (p1_en) else $error("[TB] port 1 dropped en while granted");
    compareOne("A", 0, a_gnt, a_mem_en, a_mem_addr,
               {a_mem_wr, a_mem_rburst, a_mem_wburst, a_mem_wdata},
               {a_p0_rdy, a_p1_rdy, a_p0_load, a_p1_load},
               {a_p0_rdata, a_p1_rdata, a_p0_rdata0, a_p1_rdata0});
    compareOne("B", 1, b_gnt, b_mem_en, b_mem_addr,
               {b_mem_wr, b_mem_rburst, b_mem_wburst, b_mem_wdata},
               {b_p0_rdy, b_p1_rdy, b_p0_load, b_p1_load},
               {b_p0_rdata, b_p1_rdata, b_p0_rdata0, b_p1_rdata0});
  endtask

  task automatic settle();
    #3;
    compareAll();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  // Random requesters progress on the model's byte completions; the slave answers at random.
  task automatic applyStimulus();
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && byte_done[p]) begin
        left[p]--;
        if (left[p] == 0) pend[p] = 1'b0;
        else rwdat[p] = 8'($urandom);
      end
      if (!pend[p] && $urandom_range(0, 2) == 0) begin
        pend[p]   = 1'b1;
        rwr[p]    = 1'($urandom_range(0, 1));
        left[p]   = $urandom_range(1, 4);
        raddr[p]  = 24'($urandom);
        rwdat[p]  = 8'($urandom);
        rother[p] = 1'($urandom_range(0, 1));
      end
    end
    p0_en = pend[0]; p0_wr = rwr[0]; p0_addr = raddr[0]; p0_wdata = rwdat[0];
    p0_rburst = rwr[0] ? rother[0] : (left[0] > 1);
    p0_wburst = rwr[0] ? (left[0] > 1) : rother[0];
    p1_en = pend[1]; p1_wr = rwr[1]; p1_addr = raddr[1]; p1_wdata = rwdat[1];
    p1_rburst = rwr[1] ? rother[1] : (left[1] > 1);
    p1_wburst = rwr[1] ? (left[1] > 1) : rother[1];
    mem_rdy        = ($urandom_range(0, 2) == 0);
    mem_rdata      = 8'($urandom);
    mem_rdata0     = 8'($urandom);
    mem_rdata_load = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    rst = 1'b1;
    p0_addr = '0; p1_addr = '0; p0_en = 0; p1_en = 0; p0_wr = 0; p1_wr = 0;
    p0_rburst = 0; p1_rburst = 0; p0_wburst = 0; p1_wburst = 0;
    p0_wdata = '0; p1_wdata = '0;
    mem_rdy = 0; mem_rdata = '0; mem_rdata0 = '0; mem_rdata_load = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; left[p] = 0; rwr[p] = 0; rother[p] = 0; raddr[p] = '0; rwdat[p] = '0;
    end
    advance();
    settle();
    checkOutput("reset.gnt_en", 32'({a_gnt, a_mem_en}), 32'd0);
    checkOutput("reset.strobes", 32'({a_p0_rdy, a_p1_rdy, a_p0_load, a_p1_load}), 32'd0);
    advance();
    rst = 1'b0;

    // Single-byte read from port 0.
    p0_en = 1; p0_addr = 24'h001234; p0_wr = 0;
    settle();
    checkOutput("t1.idle_gnt", 32'(a_gnt), 32'd0);
    advance();
    mem_rdy = 1; mem_rdata = 8'hA5;
    settle();
    checkOutput("t1.gnt", 32'(a_gnt), 32'd1);
    checkOutput("t1.mem_en", 32'(a_mem_en), 32'd1);
    checkOutput("t1.mem_addr", 32'(a_mem_addr), 32'h001234);
    checkOutput("t1.rdy", 32'({a_p0_rdy, a_p1_rdy}), 32'b10);
    checkOutput("t1.rdata", 32'(a_p0_rdata), 32'hA5);
    advance();
    p0_en = 0; mem_rdy = 0;
    settle();
    checkOutput("t1.release", 32'({a_gnt, a_mem_en}), 32'd0);
    advance();

    // Four-byte write burst from port 1.
    p1_en = 1; p1_wr = 1; p1_addr = 24'h00BEEF; p1_wburst = 1; p1_wdata = 8'h11;
    step();
    for (int b = 0; b < 4; b++) begin
      mem_rdy = 0;
      step();
      p1_wburst = (b < 3); p1_wdata = 8'h11 + 8'(b); mem_rdy = 1;
      settle();
      checkOutput("t2.gnt", 32'(a_gnt), 32'd2);
      checkOutput("t2.wburst", 32'(a_mem_wburst), 32'(b < 3));
      checkOutput("t2.rdy", 32'({a_p0_rdy, a_p1_rdy}), 32'b01);
      advance();
    end
    p1_en = 0; p1_wburst = 0; p1_wr = 0; mem_rdy = 0;
    settle();
    checkOutput("t2.release", 32'(a_gnt), 32'd0);
    advance();

    // Continuous contention with single-byte reads.
    rst = 1; p0_en = 1; p1_en = 1; mem_rdy = 1;
    step();
    rst = 0;
    for (int i = 0; i < 12; i++) begin
      settle();
      checkOutput("t3.order", 32'(a_gnt), 32'(exp_order_a[i]));
      checkOutput("t3.idle_gap", 32'(a_mem_en), 32'(exp_order_a[i] != 2'd0));
      checkOutput("t3.strict", 32'(b_gnt), 32'((i % 2 == 1) ? 2'd1 : 2'd0));
      advance();
    end
    p0_en = 0; p1_en = 0; mem_rdy = 0;
    step();

    // Early-data strobe during a port-1 read.
    p1_en = 1; p1_wr = 0; p1_rburst = 0;
    step();
    mem_rdata_load = 1; mem_rdata0 = 8'h3C;
    settle();
    checkOutput("t4.gnt", 32'(a_gnt), 32'd2);
    checkOutput("t4.load", 32'({a_p0_load, a_p1_load}), 32'b01);
    checkOutput("t4.rdata0", 32'(a_p1_rdata0), 32'h3C);
    advance();
    mem_rdata_load = 0; mem_rdy = 1;
    step();
    p1_en = 0; mem_rdy = 0;
    step();

    // Reset in the middle of a port-0 read burst.
    p0_en = 1; p0_wr = 0; p0_rburst = 1; p0_addr = 24'h000400;
    step();
    mem_rdy = 1;
    step();
    mem_rdy = 0; rst = 1; p1_en = 1;
    settle();
    checkOutput("t5.pre_gnt", 32'(a_gnt), 32'd1);
    advance();
    p0_en = 0; p0_rburst = 0; rst = 0;
    settle();
    checkOutput("t5.mem_en", 32'(a_mem_en), 32'd0);
    checkOutput("t5.gnt", 32'(a_gnt), 32'd0);
    checkOutput("t5.starve_cnt", 32'(dut_a.starve_cnt_q), 32'd0);
    advance();
    settle();
    checkOutput("t5.p1_first", 32'(a_gnt), 32'd2);
    advance();
    mem_rdy = 1;
    step();
    p1_en = 0; mem_rdy = 0;
    step();

    // Randomized traffic.
    rst = 1;
    step();
    rst = 0;
    repeat (600) begin
      applyStimulus();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
